uart_io_unit: RTL and testbench
===============================

UART_IO_UNIT -- requirements
Module: uart_io_unit

Interface
REQ-001 SHALL have parameter RX_DEPTH_LOG2, default 4, meaning RX byte FIFO depth = 2^RX_DEPTH_LOG2 entries.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port uart_wenable  input  1  one-cycle pulse requesting a word transmit.
REQ-005 SHALL have port uart_wsz  input  2  transmit size code, sampled with uart_wenable.
REQ-006 SHALL have port uart_wd  input  32  transmit data, sampled with uart_wenable.
REQ-007 SHALL have port uart_wdone  output  1  one-cycle pulse marking transmit completion.
REQ-008 SHALL have port uart_renable  input  1  one-cycle pulse requesting a word receive.
REQ-009 SHALL have port uart_rsz  input  2  receive size code, sampled with uart_renable.
REQ-010 SHALL have port uart_rd  output  32  assembled receive word.
REQ-011 SHALL have port uart_rdone  output  1  one-cycle pulse marking uart_rd valid.
REQ-012 SHALL have port rx_valid  input  1  one-cycle strobe from byte-level UART receiver.
REQ-013 SHALL have port rx_data  input  8  received byte, valid with rx_valid.
REQ-014 SHALL have port tx_ready  input  1  byte-level UART transmitter idle.
REQ-015 SHALL have port tx_start  output  1  byte handoff strobe to transmitter.
REQ-016 SHALL have port tx_data  output  8  byte to transmit, valid with tx_start.
REQ-017 SHALL have port rx_overrun  output  1  sticky flag: received byte dropped.

Function
REQ-018 SHALL map size code to byte count N: 00->1, 01->2, 10->3, 11->4.
REQ-019 SHALL order bytes little-endian: byte k occupies bits [8k+7:8k], byte 0 first on the wire.
REQ-020 Write FSM SHALL have states W_IDLE, W_SEND; W_IDLE->W_SEND on uart_wenable, latching uart_wd, N, byte index 0.
REQ-021 In W_SEND SHALL drive tx_start=1 and tx_data=current byte only while tx_ready=1; handshake = tx_start&&tx_ready.
REQ-022 Each handshake SHALL advance byte index; handshake on byte N-1 SHALL return to W_IDLE and pulse uart_wdone the following cycle.
REQ-023 SHALL never assert tx_start in consecutive cycles (transmitter ready drop latency of one cycle tolerated).
REQ-024 Read FSM SHALL have states R_IDLE, R_COLLECT; R_IDLE->R_COLLECT on uart_renable, clearing assembly register, latching N.
REQ-025 In R_COLLECT SHALL pop one byte per cycle while FIFO non-empty, placing it at current byte index.
REQ-026 Pop of byte N-1 SHALL return to R_IDLE; uart_rdone pulses and uart_rd updates the following cycle, unused upper bytes zero.
REQ-027 uart_rd SHALL hold its value until the next uart_rdone.
REQ-028 rx_valid SHALL push rx_data into FIFO at any FSM state; push when full and no pop same cycle SHALL drop the byte and set rx_overrun.
REQ-029 Simultaneous push and pop on full FIFO SHALL succeed with no overrun; on empty FIFO the pushed byte SHALL NOT be popped in the same cycle.
REQ-030 FIFO pointers SHALL be RX_DEPTH_LOG2+1 bits, wrapping modulo 2^(RX_DEPTH_LOG2+1); full/empty from MSB compare.
REQ-031 uart_wenable while not W_IDLE, or uart_renable while not R_IDLE, SHALL be ignored.
REQ-032 Read and write FSMs SHALL operate independently and concurrently; uart_rdone and uart_wdone may pulse in the same cycle.

Reset
REQ-033 On rstn=0 SHALL set both FSMs idle, FIFO empty, uart_wdone=0, uart_rdone=0, tx_start=0, tx_data=0, uart_rd=0, rx_overrun=0.
REQ-034 Reset mid-transfer SHALL abandon it with no done pulse; bytes arriving during reset SHALL be discarded.

Configuration
REQ-035 With macro UART_IO_RX_FIFO_EN defined SHALL implement the 2^RX_DEPTH_LOG2-entry FIFO.
REQ-036 Without UART_IO_RX_FIFO_EN SHALL implement a single-byte holding register (depth 1) with identical full/empty/overrun semantics; RX_DEPTH_LOG2 ignored.

Verification
REQ-037 uart_wenable, wsz=11, wd=32'h44332211, tx_ready=1 -> tx bytes 11,22,33,44 in order, uart_wdone one cycle after last handshake.
REQ-038 rx bytes AA,BB arrive, then uart_renable rsz=01 -> uart_rd=32'h0000BBAA with single uart_rdone pulse.
REQ-039 uart_renable rsz=11 with FIFO empty, bytes 01..04 trickled at 100-cycle gaps -> uart_rdone only after 4th byte, uart_rd=32'h04030201.
REQ-040 17 bytes pushed with no reads (FIFO_EN, depth 16) -> rx_overrun=1, subsequent 16 pops return first 16 bytes.
REQ-041 tx_ready held 0 for 50 cycles during wsz=00 send -> no tx_start, no uart_wdone until tx_ready rises; then exactly one byte.
REQ-042 rstn=0 asserted after 2nd byte of a 4-byte send -> no uart_wdone, tx_start=0, FSM accepts a new request after reset.

Source files
------------

// File: rtl/uart_io_unit.sv
// Word-level UART front end: splits 1-4 byte writes onto a byte transmitter and
// assembles 1-4 byte reads from an RX byte queue. Define UART_IO_RX_FIFO_EN for a deep RX FIFO.
module uart_io_unit #(
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uart_wenable,
    input  logic [1:0]  uart_wsz,
    input  logic [31:0] uart_wd,
    output logic        uart_wdone,
    input  logic        uart_renable,
    input  logic [1:0]  uart_rsz,
    output logic [31:0] uart_rd,
    output logic        uart_rdone,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        rx_overrun
);

`ifdef UART_IO_RX_FIFO_EN
    localparam int AW = RX_DEPTH_LOG2;
`else
    localparam int AW = (RX_DEPTH_LOG2 >= 0) ? 0 : 0;
`endif

    typedef enum logic {W_IDLE, W_SEND} wstate_t;
    typedef enum logic {R_IDLE, R_COLLECT} rstate_t;

    wstate_t     wstate;
    rstate_t     rstate;
    logic [31:0] wbuf;
    logic [1:0]  widx, wlast;
    logic        hs_prev;
    logic [31:0] racc;
    logic [1:0]  ridx, rlast;

    logic [AW:0] wptr, rptr;
    logic        full, empty, push, pop;
    logic [7:0]  pop_data;

    // ---------------- RX byte queue ----------------
    assign empty = (wptr == rptr);
    assign pop   = rstn && (rstate == R_COLLECT) && !empty;
    assign push  = rstn && rx_valid && (!full || pop);

`ifdef UART_IO_RX_FIFO_EN
    logic [7:0] mem [2**AW];

    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= rx_data;
    end
`else
    logic [7:0] hold;

    // With one-bit pointers the MSB compare alone distinguishes full from empty.
    assign full     = (wptr != rptr);
    assign pop_data = hold;

    always_ff @(posedge clk) begin
        if (push)
            hold <= rx_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr       <= '0;
            rptr       <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (rx_valid && full && !pop)
                rx_overrun <= 1'b1;
        end
    end

    // ---------------- write path ----------------
    // hs_prev forces a gap cycle so a transmitter that drops ready one cycle late is safe.
    assign tx_start = rstn && (wstate == W_SEND) && tx_ready && !hs_prev;
    assign tx_data  = tx_start ? wbuf[{widx, 3'b000} +: 8] : 8'd0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wstate     <= W_IDLE;
            wbuf       <= '0;
            widx       <= '0;
            wlast      <= '0;
            hs_prev    <= 1'b0;
            uart_wdone <= 1'b0;
        end else begin
            uart_wdone <= 1'b0;
            hs_prev    <= tx_start;
            case (wstate)
                W_IDLE: if (uart_wenable) begin
                    wbuf   <= uart_wd;
                    wlast  <= uart_wsz;
                    widx   <= '0;
                    wstate <= W_SEND;
                end
                W_SEND: if (tx_start) begin
                    if (widx == wlast) begin
                        wstate     <= W_IDLE;
                        uart_wdone <= 1'b1;
                    end else begin
                        widx <= widx + 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rstate     <= R_IDLE;
            racc       <= '0;
            ridx       <= '0;
            rlast      <= '0;
            uart_rd    <= '0;
            uart_rdone <= 1'b0;
        end else begin
            uart_rdone <= 1'b0;
            case (rstate)
                R_IDLE: if (uart_renable) begin
                    racc   <= '0;
                    rlast  <= uart_rsz;
                    ridx   <= '0;
                    rstate <= R_COLLECT;
                end
                R_COLLECT: if (pop) begin
                    if (ridx == rlast) begin
                        uart_rd    <= racc | (32'(pop_data) << {ridx, 3'b000});
                        uart_rdone <= 1'b1;
                        rstate     <= R_IDLE;
                    end else begin
                        racc <= racc | (32'(pop_data) << {ridx, 3'b000});
                        ridx <= ridx + 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_io_unit.sv
// Randomized + directed bench for uart_io_unit against a queue-based transaction model.
module tb_uart_io_unit;
`ifdef UART_IO_RX_FIFO_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk, rstn;
    logic        uart_wenable, uart_renable, rx_valid, tx_ready;
    logic [1:0]  uart_wsz, uart_rsz;
    logic [31:0] uart_wd, uart_rd;
    logic [7:0]  rx_data, tx_data;
    logic        uart_wdone, uart_rdone, tx_start, rx_overrun;

    uart_io_unit #(.RX_DEPTH_LOG2(4)) dut (
        .clk(clk), .rstn(rstn),
        .uart_wenable(uart_wenable), .uart_wsz(uart_wsz), .uart_wd(uart_wd), .uart_wdone(uart_wdone),
        .uart_renable(uart_renable), .uart_rsz(uart_rsz), .uart_rd(uart_rd), .uart_rdone(uart_rdone),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
        .tx_start(tx_start), .tx_data(tx_data), .rx_overrun(rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the DUT outputs must be in the current cycle.
    bit          m_wbusy, m_cool, m_wdone, m_rbusy, m_rdone, m_ovr;
    bit [7:0]    m_wq[$];
    bit [7:0]    m_rxq[$];
    int          m_rn, m_ridx;
    logic [31:0] m_racc, m_rd;

    bit [7:0]    txlog[$];
    int          wdone_cnt = 0;
    int          rdone_cnt = 0;

    initial begin
        m_wbusy = 0; m_cool = 0; m_wdone = 0; m_rbusy = 0; m_rdone = 0; m_ovr = 0;
        m_rn = 1; m_ridx = 0; m_racc = 0; m_rd = 0;
    end

    always @(negedge clk) begin
        bit       hs, popped;
        bit [7:0] b;
        hs = rstn && m_wbusy && tx_ready && !m_cool;
        chk("tx_start", tx_start, hs);
        if (hs && tx_start) chk("tx_data", tx_data, m_wq[0]);
        chk("wdone", uart_wdone, m_wdone);
        chk("rdone", uart_rdone, m_rdone);
        chk("rd", uart_rd, m_rd);
        chk("overrun", rx_overrun, m_ovr);
        if (tx_start && tx_ready) txlog.push_back(tx_data);
        if (uart_wdone) wdone_cnt++;
        if (uart_rdone) rdone_cnt++;

        if (!rstn) begin
            m_wbusy = 0; m_cool = 0; m_wdone = 0; m_rbusy = 0; m_rdone = 0; m_ovr = 0;
            m_wq.delete(); m_rxq.delete(); m_rd = 0;
        end else begin
            m_wdone = 0;
            m_cool  = hs;
            if (m_wbusy) begin
                if (hs) begin
                    void'(m_wq.pop_front());
                    if (m_wq.size() == 0) begin m_wbusy = 0; m_wdone = 1; end
                end
            end else if (uart_wenable) begin
                m_wbusy = 1;
                for (int k = 0; k <= int'(uart_wsz); k++) m_wq.push_back(uart_wd[8*k +: 8]);
            end

            m_rdone = 0;
            popped  = m_rbusy && (m_rxq.size() > 0);
            b       = 8'd0;
            if (popped) b = m_rxq.pop_front();
            if (rx_valid) begin
                if (m_rxq.size() < DEPTH) m_rxq.push_back(rx_data);
                else m_ovr = 1;
            end
            if (m_rbusy) begin
                if (popped) begin
                    m_racc = m_racc | (32'(b) << (8 * m_ridx));
                    m_ridx++;
                    if (m_ridx == m_rn) begin m_rbusy = 0; m_rd = m_racc; m_rdone = 1; end
                end
            end else if (uart_renable) begin
                m_rbusy = 1; m_rn = int'(uart_rsz) + 1; m_ridx = 0; m_racc = 0;
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [1:0] sz, input logic [31:0] d);
        uart_wenable = 1; uart_wsz = sz; uart_wd = d; cyc(); uart_wenable = 0;
    endtask

    task automatic rd(input logic [1:0] sz);
        uart_renable = 1; uart_rsz = sz; cyc(); uart_renable = 0;
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid = 1; rx_data = b; cyc(); rx_valid = 0;
    endtask

    task automatic wait_w(input int start, input int lim, input string name);
        int t = 0;
        while (wdone_cnt == start && t < lim) begin cyc(); t++; end
        checks++;
        if (wdone_cnt == start) begin errors++; $display("FAIL %s: no uart_wdone within %0d cycles", name, lim); end
    endtask

    task automatic wait_r(input int start, input int lim, input string name);
        int t = 0;
        while (rdone_cnt == start && t < lim) begin cyc(); t++; end
        checks++;
        if (rdone_cnt == start) begin errors++; $display("FAIL %s: no uart_rdone within %0d cycles", name, lim); end
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int       n0, c, t;
        bit [7:0] e4[4];
        e4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        rstn = 0; uart_wenable = 0; uart_renable = 0; rx_valid = 0; tx_ready = 1;
        uart_wsz = 0; uart_rsz = 0; uart_wd = 0; rx_data = 0;
        cyc(3); rstn = 1; cyc();
        chk("rst_rd", uart_rd, 32'h0);
        chk("rst_overrun", rx_overrun, 32'h0);
        chk("rst_tx_start", tx_start, 32'h0);
        chk("rst_done", {uart_wdone, uart_rdone}, 32'h0);

        // four-byte transmit, little-endian order
        n0 = txlog.size(); c = wdone_cnt;
        wr(2'b11, 32'h44332211);
        wait_w(c, 50, "w4_done");
        chk("w4_count", txlog.size() - n0, 4);
        for (int i = 0; i < 4; i++) chk("w4_byte", txlog[n0+i], e4[i]);

        // two-byte receive
        c = rdone_cnt;
        if (DEPTH >= 2) begin
            push(8'hAA); push(8'hBB); rd(2'b01);
        end else begin
            push(8'hAA); rd(2'b01); push(8'hBB);
        end
        wait_r(c, 50, "r2_done");
        cyc(2);
        chk("r2_word", uart_rd, 32'h0000BBAA);
        chk("r2_pulses", rdone_cnt - c, 1);

        // four-byte receive, bytes trickled in slowly
        c = rdone_cnt;
        rd(2'b11);
        for (int i = 1; i <= 4; i++) begin
            cyc(100);
            if (i == 4) chk("r4_early", rdone_cnt - c, 0);
            push(8'(i));
        end
        wait_r(c, 10, "r4_done");
        chk("r4_word", uart_rd, 32'h04030201);

        // transmitter stalled
        tx_ready = 0; n0 = txlog.size(); c = wdone_cnt;
        wr(2'b00, 32'h000000A5);
        cyc(50);
        chk("stall_start", txlog.size() - n0, 0);
        chk("stall_done", wdone_cnt - c, 0);
        tx_ready = 1;
        wait_w(c, 10, "stall_wdone");
        cyc(2);
        chk("stall_bytes", txlog.size() - n0, 1);
        chk("stall_byte", txlog[n0], 8'hA5);

        // reset in the middle of a send; byte arriving during reset is dropped
        n0 = txlog.size(); c = wdone_cnt; t = 0;
        wr(2'b11, 32'hDDCCBBAA);
        while (txlog.size() - n0 < 2 && t < 20) begin cyc(); t++; end
        rstn = 0; rx_valid = 1; rx_data = 8'h77;
        cyc(); rx_valid = 0; cyc();
        rstn = 1;
        cyc(20);
        chk("rst_mid_nodone", wdone_cnt - c, 0);
        chk("rst_mid_bytes", txlog.size() - n0, 2);
        c = wdone_cnt; n0 = txlog.size();
        wr(2'b00, 32'h0000005A);
        wait_w(c, 20, "post_rst_done");
        cyc();
        chk("post_rst_byte", txlog[n0], 8'h5A);

        // fill FIFO past capacity, then drain it
        for (int i = 0; i <= DEPTH; i++) push(8'h10 + 8'(i));
        cyc();
        chk("ovr_set", rx_overrun, 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            c = rdone_cnt;
            rd(2'b00);
            wait_r(c, 10, "ovr_pop_done");
            cyc();
            chk("ovr_pop", uart_rd, 32'h10 + 32'(i));
        end

        // randomized concurrent traffic
        rstn = 0; cyc(2); rstn = 1; cyc();
        for (int i = 0; i < 3000; i++) begin
            tx_ready     = ($urandom_range(0, 3) != 0);
            rx_valid     = ($urandom_range(0, 3) == 0);
            rx_data      = 8'($urandom);
            uart_wenable = ($urandom_range(0, 7) == 0);
            uart_wsz     = 2'($urandom);
            uart_wd      = $urandom;
            uart_renable = ($urandom_range(0, 7) == 0);
            uart_rsz     = 2'($urandom);
            cyc();
        end
        uart_wenable = 0; uart_renable = 0; rx_valid = 0; tx_ready = 1;
        cyc(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
